// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a classic 5-stage RV32 integer pipeline.
// It decodes the instruction held in IF/ID and keeps a shadow copy of the
// destination information for the instructions in EX and MEM. From these it:
//   - detects load-use hazards and stalls PC / IF-ID for one cycle,
//   - computes registered operand-forwarding selects for the instruction
//     that is about to enter EX,
//   - flushes the front end for BR_PENALTY cycles after a taken branch,
//   - counts lost cycles (stalls plus bubbles) in a saturating counter.
//
// Parameters
//   BR_PENALTY       bubble cycles per taken branch, including the resolve
//                    cycle (1..7)
// Ports
//   clk              clock, all state changes on the rising edge
//   reset            synchronous, active-high reset
//   id_instr[31:0]   instruction currently held in IF/ID
//   id_valid         IF/ID holds a real instruction (0 = treat as NOP)
//   ex_branch_taken  branch in EX resolved taken this cycle
//   pc_write         PC update enable
//   ifid_write       IF/ID load enable
//   ifid_flush       clear IF/ID to a NOP at the next edge
//   idex_bubble      load a NOP into ID/EX at the next edge
//   fwd_a[1:0]       rs1 select for the EX instruction: 00 regfile,
//                    10 EX/MEM, 01 MEM/WB
//   fwd_b[1:0]       rs2 select, same encoding
//   stall_count[15:0] saturating count of lost cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned BR_PENALTY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] id_instr,
   input  logic        id_valid,
   input  logic        ex_branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stall_count
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;

   localparam logic [2:0] FLUSH_RELOAD = 3'(BR_PENALTY - 1);

   // ---------------------------------------------------------------- decode
   logic [6:0] opcode;
   logic [4:0] id_rd, id_rs1, id_rs2;
   logic       use_rs1, use_rs2, id_wr, id_ld;

   assign opcode = id_instr[6:0];
   assign id_rd  = id_instr[11:7];
   assign id_rs1 = id_instr[19:15];
   assign id_rs2 = id_instr[24:20];

   // funct3 / funct7 / immediate bits do not affect hazard decisions.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      id_wr   = 1'b0;
      id_ld   = 1'b0;
      if (id_valid) begin
         unique case (opcode)
            OP_R_TYPE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; id_wr = 1'b1; end
            OP_STORE,
            OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LOAD:   begin use_rs1 = 1'b1; id_wr = 1'b1; id_ld = 1'b1; end
            OP_I_ALU:  begin use_rs1 = 1'b1; id_wr = 1'b1; end
            default:   ;
         endcase
      end
      // x0 is hard-wired to zero, so writing it produces nothing to forward.
      id_wr = id_wr && (id_rd != 5'd0);
   end

   // ------------------------------------------------------ shadow pipeline
   logic [4:0] ex_rd, mem_rd;
   logic       ex_wr, ex_ld, mem_wr;

   logic load_use;
   assign load_use = ex_ld && ex_wr &&
                     ((use_rs1 && (id_rs1 == ex_rd)) ||
                      (use_rs2 && (id_rs2 == ex_rd)));

   // Forward selects for the ID instruction, evaluated against the
   // instructions that will sit in MEM and WB once it reaches EX.
   logic [1:0] fwd_a_next, fwd_b_next;

   always_comb begin
      fwd_a_next = 2'b00;
      fwd_b_next = 2'b00;
      if (use_rs1) begin
         if (ex_wr && (ex_rd == id_rs1))        fwd_a_next = 2'b10;
         else if (mem_wr && (mem_rd == id_rs1)) fwd_a_next = 2'b01;
      end
      if (use_rs2) begin
         if (ex_wr && (ex_rd == id_rs2))        fwd_b_next = 2'b10;
         else if (mem_wr && (mem_rd == id_rs2)) fwd_b_next = 2'b01;
      end
   end

   // ------------------------------------------------------------------ FSM
   state_t     state, state_next;
   logic [2:0] flush_cnt, flush_cnt_next;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= 3'd0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      if (ex_branch_taken) begin
         // A single-cycle penalty is fully covered by the resolve cycle.
         if (BR_PENALTY > 1) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_RELOAD;
         end else begin
            state_next     = RUN;
            flush_cnt_next = 3'd0;
         end
      end else if (state == FLUSH) begin
         if (flush_cnt <= 3'd1) begin
            state_next     = RUN;
            flush_cnt_next = 3'd0;
         end else begin
            flush_cnt_next = flush_cnt - 3'd1;
         end
      end
   end

   // Branch redirect wins over a load-use stall: the stalled instruction is
   // on the wrong path and is being discarded anyway.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!reset) begin
         if (ex_branch_taken || (state == FLUSH)) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   // ------------------------------------------- shadow regs, fwd, counters
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rd  <= 5'd0;
         ex_wr  <= 1'b0;
         ex_ld  <= 1'b0;
         mem_rd <= 5'd0;
         mem_wr <= 1'b0;
         fwd_a  <= 2'b00;
         fwd_b  <= 2'b00;
      end else begin
         mem_rd <= ex_rd;
         mem_wr <= ex_wr;
         if (idex_bubble) begin
            ex_rd <= 5'd0;
            ex_wr <= 1'b0;
            ex_ld <= 1'b0;
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
         end else begin
            ex_rd <= id_rd;
            ex_wr <= id_wr;
            ex_ld <= id_ld;
            fwd_a <= fwd_a_next;
            fwd_b <= fwd_b_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= 16'd0;
      end else if ((!pc_write || idex_bubble) && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule
